// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between the core fetch port and
// instruction memory; misses fill a whole line with pipelined one-cycle reads.
module instruction_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_address,
  input  logic        core_enable,
  output logic [31:0] core_dataRead,
  output logic        core_busy,
  output logic        core_accessFault,
  input  logic        flush,
  output logic [31:0] mem_address,
  output logic        mem_enable,
  input  logic [31:0] mem_dataRead,
  input  logic        mem_busy,
  input  logic        mem_accessFault
);
  localparam int O  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(LINES);
  localparam int TW = 30 - O - I;
  localparam logic [O:0] WCNT = (O+1)'(WORDS_PER_LINE);
  localparam logic [O:0] LAST = (O+1)'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, FAULT} state_t;
  state_t state, stateNext;

  logic [O-1:0]  offset;
  logic [I-1:0]  index, fillIndex;
  logic [TW-1:0] tag, fillTag;
  logic [1:0]    unusedAddrBits;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tagMem  [LINES];
  logic [31:0]      dataMem [LINES][WORDS_PER_LINE];

  logic [31:0] lineBase;
  logic [O:0]  issueCnt, recvCnt;
  logic        faultFlag, noValidate, recvPending;
  logic        hit, accept, startFill, lastRecv, fillFault, fillOk;

  assign offset         = core_address[O+1:2];
  assign index          = core_address[O+I+1:O+2];
  assign tag            = core_address[31:O+I+2];
  assign unusedAddrBits = core_address[1:0];
  assign fillIndex      = lineBase[O+I+1:O+2];
  assign fillTag        = lineBase[31:O+I+2];

  assign hit       = valid[index] && (tagMem[index] == tag);
  assign accept    = core_enable && !core_busy;
  assign lastRecv  = (state == FILL) && recvPending && (recvCnt == LAST);
  assign fillFault = faultFlag | mem_accessFault;
  // A flush on the very edge of the last word also suppresses validation.
  assign fillOk    = lastRecv && !fillFault && !noValidate && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    core_busy   = 1'b0;
    mem_enable  = 1'b0;
    mem_address = 32'h0;
    startFill   = 1'b0;
    case (state)
      IDLE: begin
        core_busy = core_enable && !hit;
        if (core_enable && !hit) begin
          stateNext = FILL;
          startFill = 1'b1;
        end
      end
      FILL: begin
        core_busy   = core_enable;
        mem_enable  = (issueCnt < WCNT);
        mem_address = lineBase + (32'(issueCnt) << 2);
        if (lastRecv) stateNext = fillFault ? FAULT : IDLE;
      end
      FAULT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lineBase    <= 32'h0;
      issueCnt    <= '0;
      recvCnt     <= '0;
      faultFlag   <= 1'b0;
      noValidate  <= 1'b0;
      recvPending <= 1'b0;
    end else begin
      recvPending <= mem_enable && !mem_busy;
      if (state == IDLE) begin
        issueCnt   <= '0;
        recvCnt    <= '0;
        faultFlag  <= 1'b0;
        noValidate <= 1'b0;
        if (startFill) lineBase <= {core_address[31:O+2], {(O+2){1'b0}}};
      end else if (state == FILL) begin
        if (mem_enable && !mem_busy) issueCnt <= issueCnt + 1'b1;
        if (recvPending) begin
          recvCnt   <= recvCnt + 1'b1;
          faultFlag <= faultFlag | mem_accessFault;
        end
        if (flush) noValidate <= 1'b1;
      end
    end
  end

  // Line storage needs no reset; only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (state == FILL && recvPending) dataMem[fillIndex][recvCnt[O-1:0]] <= mem_dataRead;
    if (fillOk) tagMem[fillIndex] <= fillTag;
  end

  // The line being refilled is dropped up front so a faulted fill leaves it invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (flush) valid <= '0;
    else begin
      if (startFill) valid[index]     <= 1'b0;
      if (fillOk)    valid[fillIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_dataRead    <= 32'h0;
      core_accessFault <= 1'b0;
    end else if (accept) begin
      core_dataRead    <= (state == FAULT) ? 32'h0 : dataMem[index][offset];
      core_accessFault <= (state == FAULT);
    end else begin
      core_accessFault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench: stimulus queues expected fetch results from a memory
// function and a tag/valid model; a monitor checks each accepted fetch.
module tb_instruction_cache;
  localparam int LINES = 16, W = 4, O = 2, I = 4;

  logic        clk = 0, rst = 1;
  logic [31:0] core_address = 0, core_dataRead, mem_address, mem_dataRead;
  logic        core_enable = 0, core_busy, core_accessFault, flush = 0;
  logic        mem_enable, mem_busy, mem_accessFault;

  instruction_cache #(.LINES(LINES), .WORDS_PER_LINE(W)) dut (
    .clk(clk), .rst(rst), .core_address(core_address), .core_enable(core_enable),
    .core_dataRead(core_dataRead), .core_busy(core_busy),
    .core_accessFault(core_accessFault), .flush(flush),
    .mem_address(mem_address), .mem_enable(mem_enable),
    .mem_dataRead(mem_dataRead), .mem_busy(mem_busy),
    .mem_accessFault(mem_accessFault));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  typedef struct { logic [31:0] data; logic fault; logic [31:0] addr; } exp_t;
  exp_t q[$];

  bit          mValid [LINES];
  logic [31:0] mTag   [LINES];
  logic [31:0] bases  [5] = '{32'h80000000, 32'h80000100, 32'h00001000, 32'h00002000, 32'h80004000};

  int memReqs = 0, stallAt = -1, stallUsed = 0;
  bit randBusy = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a); return a; endfunction
  function automatic bit wordFault(input logic [31:0] a);
    return (a[31:24] == 8'h00) && a[12] && (a[3:2] == 2'd2);
  endfunction
  function automatic bit lineFault(input logic [31:0] a);
    bit f = 0;
    logic [31:0] b = a & ~32'(W*4-1);
    for (int k = 0; k < W; k++) f |= wordFault(b + 32'(4*k));
    return f;
  endfunction
  function automatic int idxOf(input logic [31:0] a); return int'((a >> (O+2)) % LINES); endfunction
  function automatic logic [31:0] tagOf(input logic [31:0] a); return a >> (O+I+2); endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one-cycle latency; junk on idle cycles so stray captures show up.
  always @(posedge clk) begin
    if (mem_enable && !mem_busy) begin
      mem_dataRead    <= memWord(mem_address);
      mem_accessFault <= wordFault(mem_address);
      memReqs         <= memReqs + 1;
    end else begin
      mem_dataRead    <= $urandom;
      mem_accessFault <= 1'($urandom_range(1));
    end
  end

  always @(negedge clk) begin
    if (stallAt >= 0 && memReqs == stallAt && stallUsed < 3) begin
      mem_busy  <= 1'b1;
      stallUsed <= stallUsed + 1;
    end else begin
      if (memReqs != stallAt) stallUsed <= 0;
      mem_busy <= randBusy ? ($urandom_range(3) == 0) : 1'b0;
    end
  end

  // Monitor: every accepted fetch yields one registered response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && core_enable && !core_busy) begin
        @(negedge clk);
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected accept: got data %h with nothing expected", core_dataRead);
        end else begin
          e = q.pop_front();
          chk($sformatf("data @%h", e.addr), core_dataRead, e.data);
          chk($sformatf("fault @%h", e.addr), {31'b0, core_accessFault}, {31'b0, e.fault});
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input bit flushMid, input bit checkBusy,
                        input int extraBusy, input bit keepEn);
    int idx, busyCnt, reads0, expReads, expBusy;
    bit hitP, lf;
    exp_t e;
    idx  = idxOf(a);
    lf   = lineFault(a);
    hitP = mValid[idx] && (mTag[idx] == tagOf(a));
    e.data = lf ? 32'h0 : memWord(a); e.fault = lf; e.addr = a;
    q.push_back(e);
    expReads = hitP ? 0 : (flushMid ? 2*W : W);
    expBusy  = hitP ? 0 : (flushMid ? 2*(W+2) : W+2+extraBusy);
    reads0 = memReqs; busyCnt = 0;
    core_address = a; core_enable = 1;
    forever begin
      #1;
      if (!core_busy) break;
      busyCnt++;
      if (busyCnt > 400) begin
        $display("FAIL fetch timeout @%h: busy %0d cycles, required at most %0d", a, busyCnt, expBusy);
        fails++; tests++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
      end
      if (flushMid && busyCnt == 3) flush = 1;
      @(negedge clk);
      flush = 0;
    end
    @(negedge clk);
    if (!keepEn) core_enable = 0;
    chk($sformatf("mem reads @%h", a), 32'(memReqs - reads0), 32'(expReads));
    if (checkBusy || hitP) chk($sformatf("busy cycles @%h", a), 32'(busyCnt), 32'(expBusy));
    if (!hitP) begin
      if (flushMid) for (int k = 0; k < LINES; k++) mValid[k] = 0;
      mValid[idx] = !lf;
      mTag[idx]   = tagOf(a);
    end
  endtask

  task automatic doFlush();
    core_enable = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    for (int k = 0; k < LINES; k++) mValid[k] = 0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit fm;
    for (int k = 0; k < LINES; k++) mValid[k] = 0;
    repeat (3) @(negedge clk);
    chk("reset dataRead", core_dataRead, 32'h0);
    chk("reset accessFault", {31'b0, core_accessFault}, 32'h0);
    chk("reset busy", {31'b0, core_busy}, 32'h0);
    chk("reset mem_enable", {31'b0, mem_enable}, 32'h0);
    chk("reset mem_address", mem_address, 32'h0);
    rst = 0;
    @(negedge clk);

    access(32'h80000000, 0, 1, 0, 1);
    access(32'h80000004, 0, 1, 0, 1);
    access(32'h80000008, 0, 1, 0, 1);
    access(32'h8000000C, 0, 1, 0, 0);
    access(32'h80000100, 0, 1, 0, 0);
    access(32'h80000000, 0, 1, 0, 0);
    stallAt = memReqs + 1;
    access(32'h80000020, 0, 1, 3, 0);
    stallAt = -1;
    access(32'h00001000, 0, 1, 0, 0);
    access(32'h00001004, 0, 1, 0, 0);
    access(32'h80000024, 0, 1, 0, 0);
    access(32'h80000000, 0, 1, 0, 0);
    doFlush();
    access(32'h80000000, 0, 1, 0, 0);
    access(32'h80000040, 1, 1, 0, 0);
    access(32'h80000044, 0, 1, 0, 0);

    randBusy = 1;
    repeat (250) begin
      a  = bases[$urandom_range(4)] + ($urandom_range(63) << 2);
      fm = !lineFault(a) && ($urandom_range(7) == 0);
      access(a, fm, 0, 0, 1'($urandom_range(1)));
      if (!core_enable) repeat ($urandom_range(2)) @(negedge clk);
      if ($urandom_range(15) == 0) doFlush();
    end
    core_enable = 0;
    repeat (3) @(negedge clk);
    chk("pending responses", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
